mano_fetch_unit: RTL and testbench

- Instruction-fetch sequencer for the Mano machine; sits directly upstream of the 4096x16 main memory.
- Drives the memory ADDRESS/READ lines and consumes DATA_OUT. Runs the T0..T3 fetch/decode/indirect timing sequence.
- Holds PC, AR, IR and the I bit, then hands a decoded instruction to the execute stage over a valid/done handshake.
- While the execute stage owns the instruction, it also owns the memory bus; FETCH_BUSY drives the top-level bus mux.

---
 rtl/mano_pkg.sv | 31 +++
 rtl/mano_pc_reg.sv | 31 +++
 rtl/mano_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_mano_fetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano machine fetch path: widths, states, opcodes.
package mano_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // Fetch/decode timing states; ISSUE holds a decoded instruction for execute.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T0    = 3'd1,
    T1    = 3'd2,
    T2    = 3'd3,
    T3    = 3'd4,
    ISSUE = 3'd5
  } state_e;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_LDA   = 3'd2;
  localparam logic [2:0] OP_STA   = 3'd3;
  localparam logic [2:0] OP_BUN   = 3'd4;
  localparam logic [2:0] OP_BSA   = 3'd5;
  localparam logic [2:0] OP_ISZ   = 3'd6;
  localparam logic [2:0] OP_REGIO = 3'd7;

  // Only memory-reference instructions honour the I bit as indirection.
  function automatic logic is_indirect(input logic i_bit, input logic [2:0] op);
    return i_bit && (op != OP_REGIO);
  endfunction

endpackage

// File: rtl/mano_pc_reg.sv
// Program counter: reset, branch load and +1 step (fetch or skip), load wins.
module mano_pc_reg #(
  parameter int             W         = 12,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] pc_o
);

  logic [W-1:0] pc_q, pc_d;

  // Next PC: branch target beats increment; increment wraps modulo 2^W.
  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + W'(1);
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mano_fetch_unit.sv
// Mano machine instruction fetch sequencer: T0..T3 fetch/indirect, then ISSUE
// holds the decoded instruction until the execute stage signals done.
module mano_fetch_unit #(
  parameter int                ADDR_W   = mano_pkg::ADDR_W,
  parameter int                DATA_W   = mano_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              fetch_busy_o,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] ir_out_o,
  output logic [2:0]        opcode_o,
  output logic              i_bit_o,
  output logic [ADDR_W-1:0] eff_addr_o,
  output logic              mem_ref_o,
  output logic              reg_ref_o,
  output logic              io_ref_o,
  output logic [ADDR_W-1:0] pc_out_o,
  input  logic              exec_done_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_load_value_i,
  input  logic              pc_skip_i
);

  import mano_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              i_q, i_d;
  // Decoded view is latched on ISSUE entry so it stays put while AR is
  // reloaded with PC in T0 of the following fetch.
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [2:0]        cls_q, cls_d;   // {mem_ref, reg_ref, io_ref}

  logic [ADDR_W-1:0] pc;
  logic [2:0]        ir_op;
  logic              ir_i;
  logic              done_in_issue;
  logic [2:0]        ir_cls;

  assign ir_op         = ir_q[DATA_W-2 -: 3];
  assign ir_i          = ir_q[DATA_W-1];
  assign done_in_issue = (state_q == ISSUE) && exec_done_i;
  assign ir_cls        = (ir_op != OP_REGIO) ? 3'b100 : (ir_i ? 3'b001 : 3'b010);

  mano_pc_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (done_in_issue && pc_load_i),
    .inc_i      ((state_q == T1) || (done_in_issue && pc_skip_i)),
    .load_val_i (pc_load_value_i),
    .pc_o       (pc)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ar_q    <= '0;
      ir_q    <= '0;
      i_q     <= 1'b0;
      ea_q    <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      i_q     <= i_d;
      ea_q    <= ea_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state and datapath updates for each timing step.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    i_d     = i_q;
    ea_d    = ea_q;
    cls_d   = cls_q;
    case (state_q)
      IDLE:  if (run_i) state_d = T0;
      T0: begin
        ar_d    = pc;
        state_d = T1;
      end
      T1: begin
        ir_d    = mem_data_out_i;
        state_d = T2;
      end
      T2: begin
        ar_d = ir_q[ADDR_W-1:0];
        i_d  = ir_i;
        if (is_indirect(ir_i, ir_op)) begin
          state_d = T3;
        end else begin
          ea_d    = ir_q[ADDR_W-1:0];
          cls_d   = ir_cls;
          state_d = ISSUE;
        end
      end
      T3: begin
        ar_d    = mem_data_out_i[ADDR_W-1:0];
        ea_d    = mem_data_out_i[ADDR_W-1:0];
        cls_d   = ir_cls;
        state_d = ISSUE;
      end
      ISSUE: if (exec_done_i) state_d = run_i ? T0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and handshake outputs decoded from the current state.
  always_comb begin
    mem_read_o    = (state_q == T1) || (state_q == T3);
    fetch_busy_o  = (state_q == T0) || (state_q == T1) ||
                    (state_q == T2) || (state_q == T3);
    instr_valid_o = (state_q == ISSUE);
  end

  assign mem_address_o = ar_q;
  assign ir_out_o      = ir_q;
  assign opcode_o      = ir_op;
  assign i_bit_o       = i_q;
  assign eff_addr_o    = ea_q;
  assign mem_ref_o     = cls_q[2];
  assign reg_ref_o     = cls_q[1];
  assign io_ref_o      = cls_q[0];
  assign pc_out_o      = pc;

endmodule

// File: tb/tb_mano_fetch_unit.sv
// Scoreboard bench for mano_fetch_unit: a memory model feeds the DUT, the
// driver predicts each issued instruction, a monitor checks on ISSUE entry.
module tb_mano_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, run, exec_done, pc_load, pc_skip;
  logic [11:0] pc_load_value;
  logic [11:0] mem_address, eff_addr, pc_out;
  logic        mem_read, fetch_busy, instr_valid, i_bit, mem_ref, reg_ref, io_ref;
  logic [15:0] mem_data_out, ir_out;
  logic [2:0]  opcode;

  logic [15:0] mem [0:4095];
  assign mem_data_out = mem[mem_address];

  always #5 clk = ~clk;

  mano_fetch_unit #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run),
    .mem_address_o(mem_address), .mem_read_o(mem_read), .mem_data_out_i(mem_data_out),
    .fetch_busy_o(fetch_busy), .instr_valid_o(instr_valid), .ir_out_o(ir_out),
    .opcode_o(opcode), .i_bit_o(i_bit), .eff_addr_o(eff_addr),
    .mem_ref_o(mem_ref), .reg_ref_o(reg_ref), .io_ref_o(io_ref), .pc_out_o(pc_out),
    .exec_done_i(exec_done), .pc_load_i(pc_load), .pc_load_value_i(pc_load_value),
    .pc_skip_i(pc_skip)
  );

  typedef struct {
    logic [11:0] fa;    // address the instruction is fetched from
    logic [15:0] ir;
    logic [2:0]  op;
    logic        i;
    logic [11:0] ea;
    logic [2:0]  cls;   // {mem, reg, io}
    logic [11:0] pc;    // PC seen in ISSUE
    int          reads; // memory read cycles during the fetch
    int          busy;  // busy cycles before ISSUE
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] mpc;
  logic [11:0] snap_ea, snap_pc;
  logic [2:0]  snap_op, snap_cls;
  logic        snap_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: what the Mano fetch cycle yields for the word at pc.
  function automatic exp_t predict(input logic [11:0] pc);
    exp_t e;
    logic [15:0] w;
    w     = mem[pc];
    e.fa  = pc;
    e.ir  = w;
    e.op  = w[14:12];
    e.i   = w[15];
    e.pc  = pc + 12'd1;
    if (w[14:12] == 3'd7) begin
      e.ea = w[11:0]; e.cls = w[15] ? 3'b001 : 3'b010; e.reads = 1; e.busy = 3;
    end else if (w[15]) begin
      e.ea = mem[w[11:0]][11:0]; e.cls = 3'b100; e.reads = 2; e.busy = 4;
    end else begin
      e.ea = w[11:0]; e.cls = 3'b100; e.reads = 1; e.busy = 3;
    end
    return e;
  endfunction

  // Monitor: counts fetch activity and compares against the queue on ISSUE entry.
  int          busy_cnt = 0, rd_cnt = 0;
  logic        prev_v = 1'b0;
  logic [11:0] rd_addr = '0;
  always @(negedge clk) begin
    if (!fetch_busy && !instr_valid) begin
      busy_cnt = 0; rd_cnt = 0;
    end
    if (mem_read && rd_cnt == 0) rd_addr = mem_address;
    if (mem_read) rd_cnt++;
    if (fetch_busy) busy_cnt++;
    if (instr_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue actual=1 expected=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_addr", rd_addr, e.fa);
        check("ir", ir_out, e.ir);
        check("opcode", opcode, e.op);
        check("i_bit", i_bit, e.i);
        check("eff_addr", eff_addr, e.ea);
        check("class", {mem_ref, reg_ref, io_ref}, e.cls);
        check("pc_issue", pc_out, e.pc);
        check("read_cycles", rd_cnt, e.reads);
        check("latency", busy_cnt, e.busy);
        check("issue_strobes", {mem_read, fetch_busy}, 2'b00);
      end
      busy_cnt = 0; rd_cnt = 0;
    end
    prev_v = instr_valid;
  end

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!instr_valid && n < 20) begin
      // Execute-side strobes outside ISSUE must be ignored.
      exec_done     = ($urandom_range(0, 3) == 0);
      pc_load       = $urandom_range(0, 1);
      pc_skip       = $urandom_range(0, 1);
      pc_load_value = 12'($urandom);
      @(negedge clk);
      n++;
    end
    exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    ok = instr_valid;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout actual=0 expected=1");
    end
  endtask

  // One instruction: predict, wait for ISSUE, then answer with the given PC update.
  task automatic do_instr(input bit ld, input bit sk, input logic [11:0] v, input bit drop_run);
    bit ok;
    sb.push_back(predict(mpc));
    if (drop_run) run = 1'b0;
    wait_valid(ok);
    if (!ok) return;
    snap_ea = eff_addr; snap_pc = pc_out; snap_op = opcode;
    snap_cls = {mem_ref, reg_ref, io_ref}; snap_i = i_bit;
    repeat ($urandom_range(0, 3)) begin
      pc_load = $urandom_range(0, 1); pc_skip = $urandom_range(0, 1);
      pc_load_value = 12'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b1; pc_load = ld; pc_skip = sk; pc_load_value = v;
    @(negedge clk);
    exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    mpc = ld ? v : (sk ? mpc + 12'd2 : mpc + 12'd1);
    check("pc_update", pc_out, mpc);
    if (drop_run) begin
      repeat (2) begin
        check("idle_after_drop", {fetch_busy, instr_valid, mem_read}, 3'b000);
        @(negedge clk);
      end
      run = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int n;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    mem[12'h000] = 16'h2005;
    mem[12'h001] = 16'h8010;
    mem[12'h010] = 16'h0123;
    mem[12'h002] = 16'h7800;
    mem[12'h004] = 16'hF800;
    mem[12'h050] = 16'h7800;
    mem[12'hFFF] = 16'h7800;

    rst = 1'b1; run = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    pc_load_value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_strobes", {mem_read, fetch_busy, instr_valid}, 3'b000);
    check("rst_pc", pc_out, 12'h000);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_ar", mem_address, 12'h000);
    check("rst_eff_class", {eff_addr, mem_ref, reg_ref, io_ref, i_bit}, 17'h0);
    mpc = 12'h000;

    run = 1'b1;
    do_instr(0, 0, 12'h000, 0);                 // direct LDA 005
    check("dir_eff", snap_ea, 12'h005);
    check("dir_op", snap_op, 3'd2);
    check("dir_pc", snap_pc, 12'h001);
    check("dir_cls", snap_cls, 3'b100);
    do_instr(0, 0, 12'h000, 0);                 // indirect AND via 010
    check("ind_eff", snap_ea, 12'h123);
    check("ind_i", snap_i, 1'b1);
    check("ind_op", snap_op, 3'd0);
    do_instr(0, 1, 12'h000, 0);                 // REG at 002, skip -> 004
    check("reg_cls", snap_cls, 3'b010);
    check("reg_eff", snap_ea, 12'h800);
    check("skip_pc", mpc, 12'h004);
    do_instr(1, 0, 12'h050, 0);                 // IO at 004, branch -> 050
    check("io_cls", snap_cls, 3'b001);
    do_instr(1, 1, 12'hFFF, 0);                 // load beats skip -> FFF
    do_instr(0, 1, 12'h000, 0);                 // wrap at FFF, skip -> 001
    check("wrap_pc", snap_pc, 12'h000);
    check("wrap_skip", mpc, 12'h001);

    for (int k = 0; k < 150; k++)
      do_instr($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               12'($urandom), $urandom_range(0, 7) == 0);

    // Reset while in T1 discards the fetch.
    n = 0;
    while (!(mem_read && fetch_busy && n > 0) && n < 20) begin @(negedge clk); n++; end
    sb.delete();
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_t1_strobes", {mem_read, fetch_busy, instr_valid}, 3'b000);
    check("rst_t1_pc", pc_out, 12'h000);
    check("rst_t1_class", {mem_ref, reg_ref, io_ref}, 3'b000);
    mpc = 12'h000;

    // Reset while in ISSUE.
    sb.push_back(predict(mpc));
    run = 1'b1;
    wait_valid(ok);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_issue_valid", instr_valid, 1'b0);
    check("rst_issue_pc", pc_out, 12'h000);
    check("rst_issue_ir", ir_out, 16'h0000);

    // EXEC_DONE in IDLE leaves PC alone.
    exec_done = 1'b1; pc_load = 1'b1; pc_skip = 1'b1; pc_load_value = 12'h123;
    @(negedge clk);
    exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    @(negedge clk);
    check("idle_done_pc", pc_out, 12'h000);
    check("idle_done_state", {fetch_busy, instr_valid}, 2'b00);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
